// File: rtl/btn_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : btn_frontend
//  Purpose  : Button input conditioning for the game-logic top. Two-flop
//             synchronises and debounces six raw pad lines, then publishes
//             held levels, jump/dash press edges and a jump buffer once per
//             game frame on frame_tick.
//             Bit map: 0 left, 1 right, 2 up, 3 down, 4 jump, 5 dash.
//  Options  : BTN_FRONTEND_SOCD_EN - when defined, opposing directions that
//             are both held resolve to the most recently pressed one.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int JBUF_FRAMES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] btn_raw,
  input  logic       frame_tick,
  output logic [5:0] btn,
  output logic       jump_press,
  output logic       dash_press,
  output logic [3:0] jbuf,
  output logic       frame_valid
);

  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    JBUF_LOAD = 4'(JBUF_FRAMES);

  logic [5:0] sync1_q, sync2_q;
  logic [5:0] stable_q, stable_d;
  logic [5:0] rise;
  logic [5:0] btn_filt;

  logic       jlatch_q, jlatch_d;
  logic       dlatch_q, dlatch_d;
  logic [5:0] btn_q, btn_d;
  logic       jp_q, jp_d;
  logic       dp_q, dp_d;
  logic [3:0] jbuf_q, jbuf_d;
  logic       fv_q, fv_d;

  // Two-flop synchroniser for the asynchronous pad levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: the stable level flips only after the synchronised
  // line has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  for (genvar gi = 0; gi < 6; gi++) begin : g_bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stb_d;

    // Run-length count of disagreement; flip and clear on the last one
    always_comb begin
      cnt_d = '0;
      stb_d = stable_q[gi];
      if (sync2_q[gi] != stable_q[gi]) begin
        if (cnt_q == CNT_LAST) begin
          stb_d = ~stable_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Debounce counter register
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[gi] = stb_d;
  end

  // Debounced stable vector
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_d;
    end
  end

  // A rise is the stable level flipping 0->1 on this edge
  assign rise = stable_d & ~stable_q;

`ifdef BTN_FRONTEND_SOCD_EN
  // Last-direction memory: 0 = left/up, 1 = right/down won most recently
  logic lr_q, lr_d;
  logic ud_q, ud_d;

  // Track the most recent rise per axis; a simultaneous rise favours right/down
  always_comb begin
    lr_d = lr_q;
    ud_d = ud_q;
    if (rise[1]) begin
      lr_d = 1'b1;
    end else if (rise[0]) begin
      lr_d = 1'b0;
    end
    if (rise[3]) begin
      ud_d = 1'b1;
    end else if (rise[2]) begin
      ud_d = 1'b0;
    end
  end

  // Last-direction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_q <= 1'b0;
      ud_q <= 1'b0;
    end else begin
      lr_q <= lr_d;
      ud_q <= ud_d;
    end
  end

  // Opposing pair both held: present only the most recently risen one
  always_comb begin
    btn_filt = stable_q;
    if (stable_q[1:0] == 2'b11) begin
      btn_filt[1:0] = lr_q ? 2'b10 : 2'b01;
    end
    if (stable_q[3:2] == 2'b11) begin
      btn_filt[3:2] = ud_q ? 2'b10 : 2'b01;
    end
  end
`else
  assign btn_filt = stable_q;
`endif

  // Press latches and frame-aligned output next-state
  always_comb begin
    jlatch_d = frame_tick ? rise[4] : (jlatch_q | rise[4]);
    dlatch_d = frame_tick ? rise[5] : (dlatch_q | rise[5]);
    btn_d    = btn_q;
    jp_d     = jp_q;
    dp_d     = dp_q;
    jbuf_d   = jbuf_q;
    fv_d     = frame_tick;
    if (frame_tick) begin
      btn_d = btn_filt;
      jp_d  = jlatch_q | rise[4];
      dp_d  = dlatch_q | rise[5];
      if (jp_d) begin
        jbuf_d = JBUF_LOAD;
      end else if (jbuf_q != 4'd0) begin
        jbuf_d = jbuf_q - 4'd1;
      end else begin
        jbuf_d = 4'd0;
      end
    end
  end

  // Latch and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      jlatch_q <= 1'b0;
      dlatch_q <= 1'b0;
      btn_q    <= '0;
      jp_q     <= 1'b0;
      dp_q     <= 1'b0;
      jbuf_q   <= '0;
      fv_q     <= 1'b0;
    end else begin
      jlatch_q <= jlatch_d;
      dlatch_q <= dlatch_d;
      btn_q    <= btn_d;
      jp_q     <= jp_d;
      dp_q     <= dp_d;
      jbuf_q   <= jbuf_d;
      fv_q     <= fv_d;
    end
  end

  assign btn         = btn_q;
  assign jump_press  = jp_q;
  assign dash_press  = dp_q;
  assign jbuf        = jbuf_q;
  assign frame_valid = fv_q;

endmodule
`default_nettype wire

// File: doc/btn_frontend.md
Name: btn_frontend

Overview:
- Input conditioning stage directly upstream of the game-logic top; produces its `btn` bus.
- Synchronises and debounces six raw pad lines, then samples them once per game frame on `frame_tick`.
- Generates frame-aligned held, pressed-edge and jump-buffer information.
- Bit map: 0 left, 1 right, 2 up, 3 down, 4 jump, 5 dash.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised line must differ from its stable value before the stable value flips (>=1).
- JBUF_FRAMES, 4, jump-buffer reload value in frames (1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- btn_raw  input  6  asynchronous raw button levels, 1 = pressed.
- frame_tick  input  1  single-cycle pulse, one per game frame.
- btn  output  6  debounced held levels, updated only on frame_tick.
- jump_press  output  1  jump newly pressed during the frame just closed.
- dash_press  output  1  dash newly pressed during the frame just closed.
- jbuf  output  4  jump-buffer frames remaining.
- frame_valid  output  1  pulses one cycle after frame_tick when outputs are updated.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset state:
  - Synchroniser flops, stable vector, debounce counters, press latches, btn, jump_press, dash_press, jbuf and frame_valid all 0.
  - SOCD last-direction register is 0 (left).
- Synchroniser: 2 flops per bit. Raw-to-stable latency is 2 + DEBOUNCE_CYCLES cycles.
- Debounce, per bit:
  - Counter clears whenever sync == stable.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync still differs, stable flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Counter width is clog2(DEBOUNCE_CYCLES+1); no wrap.
- Press latch (bits 4 and 5):
  - Set on any cycle where stable rises.
  - Cleared on frame_tick, unless a rise occurs in that same cycle; then the latch stays set for the next frame.
  - A press and release within one frame is therefore never lost.
- On frame_tick (registered; visible next cycle together with frame_valid = 1):
  - btn <= stable, after optional SOCD filtering.
  - jump_press <= jump latch | (rise of stable[4] this cycle).
  - dash_press <= dash latch | (rise of stable[5] this cycle).
  - jbuf <= JBUF_FRAMES if the new jump_press is 1; else jbuf-1 if jbuf > 0; else 0. Saturates at 0, never wraps.
- Between ticks all outputs hold. frame_valid is 0 except the cycle after a tick.
- Back-to-back frame_tick on consecutive cycles: each tick is processed independently; the second sees the latches already cleared.
- Reset mid-frame: all state clears in the same cycle. Pending latches are discarded. A button held through reset must re-debounce (DEBOUNCE_CYCLES) before appearing; it is not reported as a press unless stable rises after reset.
- frame_tick asserted during rst is ignored.

Optional Feature:
- Macro: BTN_FRONTEND_SOCD_EN.
- Defined:
  - When stable[0] and stable[1] are both 1, btn presents only the most recently risen of the two.
  - A 1-bit last-direction register updates on each rise of stable[0] or stable[1]. Simultaneous rise selects right.
  - Same rule applies to up/down (bits 2/3) with its own register.
- Undefined: btn = stable unmodified; opposing bits may both be 1.

Test Plan:
- Debounce: DEBOUNCE_CYCLES=16; pulse btn_raw[0] high for 10 cycles, then hold it high. Stable must not change during the pulse. btn[0] = 1 only at the first frame_tick at least 18 cycles after the sustained rise.
- Sub-frame press: frame period 1000 cycles; btn_raw[4] high for 40 cycles mid-frame, then low. At the next tick: jump_press = 1, jbuf = 4, btn[4] = 0. Following ticks: jbuf = 3, 2, 1, 0, 0; jump_press = 0.
- Rebuffer: jump pressed; jbuf reaches 2; press again. Next tick jbuf = 4.
- Held jump: btn_raw[4] held across 5 ticks. jump_press = 1 on the first tick only; btn[4] = 1 on all five.
- Reset mid-frame: dash latched, rst asserted for 1 cycle before the tick. At the tick after reset: dash_press = 0 and all outputs 0.
- SOCD, with the macro defined: press left, then right 100 cycles later, both held. btn[1:0] = 2'b10. Release right: btn[1:0] = 2'b01. Without the macro: 2'b11, then 2'b01.
